// File: rtl/thermistor_pkg.sv
// Shared NTC thermistor constants: calibration table, fault thresholds and decoder FSM states.
// Also consumed by the heater_control target-temp conversion.
package thermistor_pkg;

  localparam int N_PTS     = 32;
  localparam int TEMP_STEP = 10;

  localparam logic [11:0] ADC_OPEN  = 12'd4000;
  localparam logic [11:0] ADC_SHORT = 12'd20;

  // ADC code at 0, 10, 20 ... 310 C; strictly decreasing (NTC gets hotter -> lower code)
  localparam logic [0:N_PTS-1][11:0] LUT = {
    12'd3900, 12'd3780, 12'd3600, 12'd3400, 12'd3150, 12'd2880, 12'd2600, 12'd2320,
    12'd2050, 12'd1800, 12'd1570, 12'd1370, 12'd1190, 12'd1030, 12'd890,  12'd770,
    12'd665,  12'd575,  12'd500,  12'd435,  12'd380,  12'd332,  12'd291,  12'd256,
    12'd226,  12'd200,  12'd178,  12'd159,  12'd142,  12'd127,  12'd114,  12'd102
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    SEARCH = 2'd2,
    DIVIDE = 2'd3
  } state_t;

endpackage

// File: rtl/thermistor_lut.sv
// Combinational two-port read of the NTC calibration table.
module thermistor_lut
  import thermistor_pkg::*;
(
  input  logic [4:0]  addr_a,
  input  logic [4:0]  addr_b,
  output logic [11:0] code_a,
  output logic [11:0] code_b
);

  assign code_a = LUT[addr_a];
  assign code_b = LUT[addr_b];

endmodule

// File: rtl/thermistor_decoder.sv
// Converts a filtered NTC ADC code to signed degrees C by linear search of the
// calibration table followed by a 4-step restoring divide inside the segment.
module thermistor_decoder
  import thermistor_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        adc_code,
  input  logic               sample_valid,
  output logic               busy,
  output logic signed [11:0] temp_c,
  output logic               temp_valid,
  output logic               fault_open,
  output logic               fault_short,
  output logic               overrun
);

  state_t      state, state_nxt;
  logic [11:0] code_r;
  logic [4:0]  idx;
  logic [4:0]  seg;
  logic [15:0] rem;
  logic [11:0] den;
  logic [2:0]  quo;
  logic [1:0]  step;
  logic [11:0] lut_a, lut_b;
  logic [11:0] diff_a;
  logic [15:0] den_sh;
  logic        q_bit;
  logic [3:0]  q_fin;
  logic [11:0] seg_temp;
  logic        is_open, is_short, is_cold, is_hot, saturate, found;

  function automatic logic [15:0] mul10(input logic [15:0] x);
    return 16'((x << 3) + (x << 1));
  endfunction

  // Port a = lower-temperature end of the candidate segment, port b = the entry under test
  thermistor_lut u_lut (
    .addr_a (idx - 5'd1),
    .addr_b (idx),
    .code_a (lut_a),
    .code_b (lut_b)
  );

  assign busy     = (state != IDLE);
  assign is_open  = (code_r >= ADC_OPEN);
  assign is_short = (code_r <= ADC_SHORT);
  assign is_cold  = (code_r >= LUT[0]);
  assign is_hot   = (code_r <= LUT[N_PTS-1]);
  assign saturate = is_open | is_short | is_cold | is_hot;
  assign found    = (code_r > lut_b);
  assign diff_a   = lut_a - code_r;

  // Quotient is known to be below 10, so trial subtraction starts at den*8
  assign den_sh   = {4'd0, den} << step;
  assign q_bit    = (rem >= den_sh);
  assign q_fin    = {quo, q_bit};
  assign seg_temp = 12'(mul10({11'd0, seg}) + {12'd0, q_fin});

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sample_valid) state_nxt = CHECK;
      CHECK:   state_nxt = saturate ? IDLE : SEARCH;
      SEARCH:  if (found) state_nxt = DIVIDE;
      DIVIDE:  if (step == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      temp_c      <= '0;
      temp_valid  <= 1'b0;
      fault_open  <= 1'b0;
      fault_short <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state      <= state_nxt;
      temp_valid <= 1'b0;
      if (sample_valid && busy) overrun <= 1'b1;
      if (state == CHECK && saturate) begin
        temp_valid  <= 1'b1;
        fault_open  <= is_open;
        fault_short <= is_short & ~is_open;
        if (is_open || is_short) temp_c <= -12'sd1;
        else if (is_cold)        temp_c <= 12'sd0;
        else                     temp_c <= 12'sd310;
      end else if (state == DIVIDE && step == 2'd0) begin
        temp_valid  <= 1'b1;
        fault_open  <= 1'b0;
        fault_short <= 1'b0;
        temp_c      <= $signed(seg_temp);
      end
    end
  end

  // Datapath registers carry no reset; each is loaded before it is consumed
  always_ff @(posedge clk) begin
    if (state == IDLE && sample_valid) code_r <= adc_code;
    case (state)
      CHECK: idx <= 5'd1;
      SEARCH: begin
        if (found) begin
          seg  <= idx - 5'd1;
          rem  <= mul10({4'd0, diff_a});
          den  <= lut_a - lut_b;
          quo  <= 3'd0;
          step <= 2'd3;
        end else begin
          idx <= idx + 5'd1;
        end
      end
      DIVIDE: begin
        if (q_bit) rem <= rem - den_sh;
        quo  <= q_fin[2:0];
        step <= step - 2'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_thermistor_decoder.sv
// Directed bench for thermistor_decoder: saturation, faults, segment interpolation,
// overrun handling and mid-conversion reset.
module tb_thermistor_decoder;

  logic               clk = 1'b0;
  logic               rst;
  logic [11:0]        adc_code;
  logic               sample_valid;
  logic               busy;
  logic signed [11:0] temp_c;
  logic               temp_valid;
  logic               fault_open;
  logic               fault_short;
  logic               overrun;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_pulse  = 0;
  int   n_back   = 0;
  logic tv_prev  = 1'b0;

  always #5 clk = ~clk;

  thermistor_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .adc_code     (adc_code),
    .sample_valid (sample_valid),
    .busy         (busy),
    .temp_c       (temp_c),
    .temp_valid   (temp_valid),
    .fault_open   (fault_open),
    .fault_short  (fault_short),
    .overrun      (overrun)
  );

  always @(posedge clk) begin
    if (temp_valid === 1'b1) n_pulse++;
    if (temp_valid === 1'b1 && tv_prev === 1'b1) n_back++;
    tv_prev <= temp_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic convert(input logic [11:0] code, input int exp_t, input logic eo,
                         input logic es, input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    adc_code     = code;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (temp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_temp"}, temp_c, exp_t);
    chk({tag, "_open"}, 32'(fault_open), 32'(eo));
    chk({tag, "_short"}, 32'(fault_short), 32'(es));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_tv_drop"}, 32'(temp_valid), 32'd0);
    chk({tag, "_hold"}, temp_c, exp_t);
  endtask

  initial begin
    int lat;
    int p0;
    rst          = 1'b1;
    sample_valid = 1'b0;
    adc_code     = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_temp", temp_c, 32'd0);
    chk("rst_tv", 32'(temp_valid), 32'd0);
    chk("rst_open", 32'(fault_open), 32'd0);
    chk("rst_short", 32'(fault_short), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    convert(12'd3500, 25,  1'b0, 1'b0, 8,  "mid_3500");
    convert(12'd4095, -1,  1'b1, 1'b0, 1,  "open_4095");
    convert(12'd5,    -1,  1'b0, 1'b1, 1,  "short_5");
    convert(12'd4000, -1,  1'b1, 1'b0, 1,  "open_edge");
    convert(12'd20,   -1,  1'b0, 1'b1, 1,  "short_edge");
    convert(12'd3901, 0,   1'b0, 1'b0, 1,  "cold_sat");
    convert(12'd102,  310, 1'b0, 1'b0, 1,  "hot_sat");
    convert(12'd21,   310, 1'b0, 1'b0, 1,  "hot_21");
    convert(12'd2880, 50,  1'b0, 1'b0, 11, "exact_lut5");
    convert(12'd3150, 40,  1'b0, 1'b0, 10, "exact_lut4");
    convert(12'd3779, 10,  1'b0, 1'b0, 7,  "lut1_m1");
    convert(12'd1000, 132, 1'b0, 1'b0, 19, "seg13");
    convert(12'd3000, 45,  1'b0, 1'b0, 10, "seg4");
    convert(12'd110,  303, 1'b0, 1'b0, 36, "seg30");
    chk("no_overrun_yet", 32'(overrun), 32'd0);

    // sample_valid held for three edges; later codes must be ignored
    @(negedge clk);
    adc_code     = 12'd3500;
    sample_valid = 1'b1;
    p0           = n_pulse;
    @(posedge clk); #1;
    adc_code = 12'd4095;
    chk("hold_ovr_e0", 32'(overrun), 32'd0);
    @(posedge clk); #1;
    chk("hold_ovr_e1", 32'(overrun), 32'd1);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    lat = 2;
    while (temp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_lat", lat, 8);
    chk("hold_temp", temp_c, 25);
    chk("hold_open", 32'(fault_open), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("hold_one_conv", n_pulse - p0, 1);
    chk("hold_ovr_sticky", 32'(overrun), 32'd1);

    convert(12'd4095, -1, 1'b1, 1'b0, 1, "pre_rst_open");
    chk("ovr_still_set", 32'(overrun), 32'd1);

    // Reset asserted while the divider is running
    @(negedge clk);
    adc_code     = 12'd3500;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("div_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    p0  = n_pulse;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_temp", temp_c, 32'd0);
    chk("abort_tv", 32'(temp_valid), 32'd0);
    chk("abort_open", 32'(fault_open), 32'd0);
    chk("abort_short", 32'(fault_short), 32'd0);
    chk("abort_ovr", 32'(overrun), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_pulse", n_pulse - p0, 0);

    convert(12'd3500, 25, 1'b0, 1'b0, 8, "post_rst");
    chk("no_back_to_back", n_back, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
